// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV instruction-decode stage: opcodes, ALU op codes,
// access sizes, jump / writeback-source encodings, the canonical NOP and the
// packed control-signal bundle carried from decode to EX.
package rv_ctrl_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU operations
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;
  localparam logic [3:0] ALU_BEQ = 4'd10;
  localparam logic [3:0] ALU_BNE = 4'd11;
  localparam logic [3:0] ALU_BGE = 4'd12;
  localparam logic [3:0] ALU_BLT = 4'd13;

  // Memory access sizes
  localparam logic [1:0] SIZE_WORD   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_BYTE   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  // Control-flow kinds
  localparam logic [1:0] JUMP_NONE   = 2'b00;
  localparam logic [1:0] JUMP_BRANCH = 2'b01;
  localparam logic [1:0] JUMP_JALR   = 2'b10;
  localparam logic [1:0] JUMP_JAL    = 2'b11;

  // Writeback source
  localparam logic [1:0] M2R_NONE = 2'd0;
  localparam logic [1:0] M2R_MEM  = 2'd1;
  localparam logic [1:0] M2R_ALU  = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Control bundle; reg_write is active low
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] mem_to_reg;
    logic [1:0] jump;
    logic [3:0] alu_op;
    logic [1:0] inst_size;
    logic       is_signed;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    mem_read:   1'b0,
    mem_write:  1'b0,
    reg_write:  1'b1,
    alu_src:    1'b0,
    mem_to_reg: M2R_NONE,
    jump:       JUMP_NONE,
    alu_op:     ALU_ADD,
    inst_size:  SIZE_WORD,
    is_signed:  1'b1
  };

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV instruction decoder.
// Build option: RV_M_EXT_EN enables decode of mul/mulh/mulhsu/mulhu.
// Ports:
//   inst            in  32    instruction word
//   ctrl            out       control bundle (NOP values when illegal)
//   rs1, rs2, rd    out 5     register indices, 0 when the field is unused
//   imm             out XLEN  sign-extended immediate, 0 when unused
//   illegal         out 1     unknown opcode / funct combination
//   use_rs1/use_rs2 out 1     instruction actually reads that source
module rv_decode_comb
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output ctrl_t           ctrl,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            use_rs1,
  output logic            use_rs2
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [6:0]      shamt_hi;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            use_rd;
  logic            bad;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // RV64 shift amounts are 6 bits, so bit 25 belongs to shamt there
  assign shamt_hi = RV64 ? {inst[31:26], 1'b0} : inst[31:25];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  // Opcode/funct decode; any illegal result collapses to NOP controls
  always_comb begin
    ctrl    = CTRL_NOP;
    imm     = '0;
    bad     = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = M2R_ALU;
        ctrl.reg_write  = 1'b0;
        ctrl.alu_op     = (opcode == OPC_LUI) ? ALU_LUI : ALU_ADD;
        use_rd          = 1'b1;
        imm             = imm_u;
      end
      OPC_OP_IMM: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = M2R_ALU;
        ctrl.reg_write  = 1'b0;
        use_rs1         = 1'b1;
        use_rd          = 1'b1;
        imm             = imm_i;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b001: begin
            ctrl.alu_op = ALU_SHL;
            bad         = (shamt_hi != 7'b0000000);
          end
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b011: begin
            ctrl.alu_op    = ALU_SLT;
            ctrl.is_signed = 1'b0;
          end
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b101: begin
            ctrl.alu_op = ALU_SHR;
            bad         = (shamt_hi != 7'b0000000) && (shamt_hi != 7'b0100000);
          end
          3'b110: ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = M2R_MEM;
        ctrl.reg_write  = 1'b0;
        use_rs1         = 1'b1;
        use_rd          = 1'b1;
        imm             = imm_i;
        case (funct3)
          3'b000: ctrl.inst_size = SIZE_BYTE;
          3'b001: ctrl.inst_size = SIZE_HALF;
          3'b010: ctrl.inst_size = SIZE_WORD;
          3'b011: begin
            ctrl.inst_size = SIZE_DOUBLE;
            bad            = !RV64;
          end
          3'b100: begin
            ctrl.inst_size = SIZE_BYTE;
            ctrl.is_signed = 1'b0;
          end
          3'b101: begin
            ctrl.inst_size = SIZE_HALF;
            ctrl.is_signed = 1'b0;
          end
          3'b110: begin
            ctrl.inst_size = SIZE_WORD;
            ctrl.is_signed = 1'b0;
            bad            = !RV64;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        imm            = imm_s;
        case (funct3)
          3'b000: ctrl.inst_size = SIZE_BYTE;
          3'b001: ctrl.inst_size = SIZE_HALF;
          3'b010: ctrl.inst_size = SIZE_WORD;
          3'b011: begin
            ctrl.inst_size = SIZE_DOUBLE;
            bad            = !RV64;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP: begin
        ctrl.mem_to_reg = M2R_ALU;
        ctrl.reg_write  = 1'b0;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        use_rd          = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: ctrl.alu_op = ALU_ADD;
              3'b001: ctrl.alu_op = ALU_SHL;
              3'b010: ctrl.alu_op = ALU_SLT;
              3'b011: begin
                ctrl.alu_op    = ALU_SLT;
                ctrl.is_signed = 1'b0;
              end
              3'b100: ctrl.alu_op = ALU_XOR;
              3'b101: ctrl.alu_op = ALU_SHR;
              3'b110: ctrl.alu_op = ALU_OR;
              default: ctrl.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000: ctrl.alu_op = ALU_SUB;
              3'b101: ctrl.alu_op = ALU_SHR;
              default: bad = 1'b1;
            endcase
          end
          7'b0000001: begin
`ifdef RV_M_EXT_EN
            // Multiply group; div/rem encodings (funct3[2]=1) decode as illegal
            ctrl.alu_op = ALU_MUL;
            bad         = funct3[2];
`else
            bad = 1'b1;
`endif
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        ctrl.jump = JUMP_BRANCH;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        imm       = imm_b;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_BEQ;
          3'b001: ctrl.alu_op = ALU_BNE;
          3'b100: ctrl.alu_op = ALU_BLT;
          3'b101: ctrl.alu_op = ALU_BGE;
          3'b110: begin
            ctrl.alu_op    = ALU_BLT;
            ctrl.is_signed = 1'b0;
          end
          3'b111: begin
            ctrl.alu_op    = ALU_BGE;
            ctrl.is_signed = 1'b0;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        ctrl.jump       = JUMP_JAL;
        ctrl.mem_to_reg = M2R_ALU;
        ctrl.reg_write  = 1'b0;
        use_rd          = 1'b1;
        imm             = imm_j;
      end
      OPC_JALR: begin
        ctrl.jump       = JUMP_JALR;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = M2R_ALU;
        ctrl.reg_write  = 1'b0;
        use_rs1         = 1'b1;
        use_rd          = 1'b1;
        imm             = imm_i;
        bad             = (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl    = CTRL_NOP;
      imm     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
    end
  end

  assign illegal = bad;
  assign rs1     = use_rs1 ? inst[19:15] : 5'd0;
  assign rs2     = use_rs2 ? inst[24:20] : 5'd0;
  assign rd      = use_rd  ? inst[11:7]  : 5'd0;

endmodule

// File: rtl/id_control_pipe.sv
// Registered instruction-decode stage between fetch and EX.
// Build option: RV_M_EXT_EN (multiply decode, passed through to rv_decode_comb).
// Ports:
//   clk, reset                  clock, async active-high reset
//   in_valid/in_ready           fetch handshake (in_ready is combinational)
//   in_inst, in_pc              instruction word and its PC
//   flush                       kill held and incoming instruction
//   out_valid/out_ready         EX handshake
//   out_inst, out_pc            held instruction and PC (NOP/0 for bubbles)
//   out_rs1/rs2/rd, out_imm     register indices and sign-extended immediate
//   out_mem_read ... out_is_signed  control bundle (out_reg_write active low)
//   out_illegal                 held instruction was not decodable
//   perf_bubbles                saturating count of load-use bubbles
module id_control_pipe
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_alu_src,
  output logic              out_reg_write,
  output logic [1:0]        out_mem_to_reg,
  output logic [1:0]        out_jump,
  output logic [3:0]        out_alu_op,
  output logic [1:0]        out_inst_size,
  output logic              out_is_signed,
  output logic              out_illegal,
  output logic [PERF_W-1:0] perf_bubbles
);

  ctrl_t           dec_ctrl;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal, dec_use_rs1, dec_use_rs2;
  ctrl_t           ctrl_q;
  logic            hazard;
  logic            take_in;

  rv_decode_comb #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .ctrl    (dec_ctrl),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .imm     (dec_imm),
    .illegal (dec_illegal),
    .use_rs1 (dec_use_rs1),
    .use_rs2 (dec_use_rs2)
  );

  // Load-use: held load targets a register the incoming instruction reads
  assign hazard = out_valid && ctrl_q.mem_read && (out_rd != 5'd0) && in_valid &&
                  ((dec_use_rs1 && (dec_rs1 == out_rd)) ||
                   (dec_use_rs2 && (dec_rs2 == out_rd)));

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign take_in  = in_valid && in_ready;

  // Output register: accept new decode, otherwise drain/flush/bubble to NOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      ctrl_q       <= CTRL_NOP;
      out_inst     <= NOP_INST;
      out_pc       <= '0;
      out_rs1      <= 5'd0;
      out_rs2      <= 5'd0;
      out_rd       <= 5'd0;
      out_imm      <= '0;
      out_illegal  <= 1'b0;
      perf_bubbles <= '0;
    end else begin
      // take_in already excludes flush and hazard
      if (hazard && out_ready && !flush && (perf_bubbles != '1)) begin
        perf_bubbles <= perf_bubbles + PERF_W'(1);
      end
      if (take_in) begin
        out_valid   <= 1'b1;
        ctrl_q      <= dec_ctrl;
        out_inst    <= in_inst;
        out_pc      <= in_pc;
        out_rs1     <= dec_rs1;
        out_rs2     <= dec_rs2;
        out_rd      <= dec_rd;
        out_imm     <= dec_imm;
        out_illegal <= dec_illegal;
      end else if (flush || out_ready || !out_valid) begin
        out_valid   <= 1'b0;
        ctrl_q      <= CTRL_NOP;
        out_inst    <= NOP_INST;
        out_pc      <= '0;
        out_rs1     <= 5'd0;
        out_rs2     <= 5'd0;
        out_rd      <= 5'd0;
        out_imm     <= '0;
        out_illegal <= 1'b0;
      end
    end
  end

  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_jump       = ctrl_q.jump;
  assign out_alu_op     = ctrl_q.alu_op;
  assign out_inst_size  = ctrl_q.inst_size;
  assign out_is_signed  = ctrl_q.is_signed;

endmodule

// File: tb/tb_id_control_pipe.sv
// Scoreboard bench for id_control_pipe: stimulus pushes hand-computed expected
// decode results, a monitor pops and compares on every output transfer.
module tb_id_control_pipe;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        as;
    logic [1:0]  m2r;
    logic [1:0]  j;
    logic [3:0]  op;
    logic [1:0]  sz;
    logic        sg;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = 32'h0, in_pc = 32'h0;
  logic        in_ready, out_valid;
  logic [31:0] out_inst, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_mem_read, out_mem_write, out_alu_src, out_reg_write;
  logic [1:0]  out_mem_to_reg, out_jump, out_inst_size;
  logic [3:0]  out_alu_op;
  logic        out_is_signed, out_illegal;
  logic [15:0] perf_bubbles;

  // RV64 instance
  logic        in_valid64 = 1'b0;
  logic [31:0] in_inst64 = 32'h0;
  logic [63:0] in_pc64 = 64'h0;
  logic        in_ready64, out_valid64;
  logic [31:0] out_inst64;
  logic [63:0] out_pc64, out_imm64;
  logic [4:0]  out_rs1_64, out_rs2_64, out_rd_64;
  logic        out_mem_read64, out_mem_write64, out_alu_src64, out_reg_write64;
  logic [1:0]  out_mem_to_reg64, out_jump64, out_inst_size64;
  logic [3:0]  out_alu_op64;
  logic        out_is_signed64, out_illegal64;
  logic [15:0] perf_bubbles64;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  id_control_pipe #(.XLEN(32), .PERF_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_alu_src(out_alu_src),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg), .out_jump(out_jump),
    .out_alu_op(out_alu_op), .out_inst_size(out_inst_size), .out_is_signed(out_is_signed),
    .out_illegal(out_illegal), .perf_bubbles(perf_bubbles)
  );

  id_control_pipe #(.XLEN(64), .PERF_W(16)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_inst(in_inst64), .in_pc(in_pc64), .flush(1'b0),
    .out_valid(out_valid64), .out_ready(1'b1), .out_inst(out_inst64), .out_pc(out_pc64),
    .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_rd(out_rd_64), .out_imm(out_imm64),
    .out_mem_read(out_mem_read64), .out_mem_write(out_mem_write64), .out_alu_src(out_alu_src64),
    .out_reg_write(out_reg_write64), .out_mem_to_reg(out_mem_to_reg64), .out_jump(out_jump64),
    .out_alu_op(out_alu_op64), .out_inst_size(out_inst_size64), .out_is_signed(out_is_signed64),
    .out_illegal(out_illegal64), .perf_bubbles(perf_bubbles64)
  );

  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] rd, input logic [31:0] imm,
                              input logic [31:0] mr, input logic [31:0] mw,
                              input logic [31:0] rw, input logic [31:0] as,
                              input logic [31:0] m2r, input logic [31:0] j,
                              input logic [31:0] op, input logic [31:0] sz,
                              input logic [31:0] sg, input logic [31:0] ill);
    exp_t e;
    e.inst = inst;      e.pc = pc;
    e.rs1 = 5'(rs1);    e.rs2 = 5'(rs2);   e.rd = 5'(rd);   e.imm = imm;
    e.mr = 1'(mr);      e.mw = 1'(mw);     e.rw = 1'(rw);   e.as = 1'(as);
    e.m2r = 2'(m2r);    e.j = 2'(j);       e.op = 4'(op);   e.sz = 2'(sz);
    e.sg = 1'(sg);      e.ill = 1'(ill);
    return e;
  endfunction

  // Illegal instruction: NOP controls, inst/pc kept
  function automatic exp_t nop_exp(input logic [31:0] inst, input logic [31:0] pc);
    return mk(inst, pc, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, got, req);
    end
  endtask

  task automatic send(input string nm, input logic [31:0] i, input logic [31:0] p,
                      input exp_t e, input bit push, output int waits);
    int   n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    in_valid = 1'b1;
    in_inst = i;
    in_pc = p;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout actual=in_ready_low required=accept_within_20", nm);
    end else if (push) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    #1;
    in_valid = 1'b0;
    waits = n;
  endtask

  // Monitor: compare every output transfer against the scoreboard head
  initial begin : monitor
    exp_t  e, got;
    string nm;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        got.inst = out_inst;        got.pc = out_pc;
        got.rs1 = out_rs1;          got.rs2 = out_rs2;       got.rd = out_rd;
        got.imm = out_imm;          got.mr = out_mem_read;   got.mw = out_mem_write;
        got.rw = out_reg_write;     got.as = out_alu_src;    got.m2r = out_mem_to_reg;
        got.j = out_jump;           got.op = out_alu_op;     got.sz = out_inst_size;
        got.sg = out_is_signed;     got.ill = out_illegal;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer actual=inst_%h required=no_output", out_inst);
        end else begin
          e = exp_q.pop_front();
          nm = name_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, got, e);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] vi[11];
    exp_t        ve[11];
    exp_t        e_mul;
    int          w;

    vi[0]  = 32'h00500093; ve[0]  = mk(vi[0],  32'h100, 0,0,1, 5,            0,0,0,1, 2,0, 0, 0,1,0);
    vi[1]  = 32'h402081B3; ve[1]  = mk(vi[1],  32'h104, 1,2,3, 0,            0,0,0,0, 2,0, 1, 0,1,0);
    vi[2]  = 32'h123452B7; ve[2]  = mk(vi[2],  32'h108, 0,0,5, 32'h12345000, 0,0,0,1, 2,0, 9, 0,1,0);
    vi[3]  = 32'h0020A423; ve[3]  = mk(vi[3],  32'h10C, 1,2,0, 8,            0,1,1,1, 0,0, 0, 0,1,0);
    vi[4]  = 32'hFE209EE3; ve[4]  = mk(vi[4],  32'h110, 1,2,0, 32'hFFFFFFFC, 0,0,1,0, 0,1, 11,0,1,0);
    vi[5]  = 32'h0041E863; ve[5]  = mk(vi[5],  32'h114, 3,4,0, 16,           0,0,1,0, 0,1, 13,0,0,0);
    vi[6]  = 32'h001000EF; ve[6]  = mk(vi[6],  32'h118, 0,0,1, 32'h800,      0,0,0,0, 2,3, 0, 0,1,0);
    vi[7]  = 32'h00008067; ve[7]  = mk(vi[7],  32'h11C, 1,0,0, 0,            0,0,0,1, 2,2, 0, 0,1,0);
    vi[8]  = 32'h0010B393; ve[8]  = mk(vi[8],  32'h120, 1,0,7, 1,            0,0,0,1, 2,0, 8, 0,0,0);
    vi[9]  = 32'hFFF14303; ve[9]  = mk(vi[9],  32'h124, 2,0,6, 32'hFFFFFFFF, 1,0,0,1, 1,0, 0, 2,0,0);
    vi[10] = 32'hFFFFFFFF; ve[10] = nop_exp(vi[10], 32'h128);

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_reg_write", 64'(out_reg_write), 64'd1);
    chk("rst_alu_op", 64'(out_alu_op), 64'd0);
    chk("rst_perf", 64'(perf_bubbles), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'h13);
    @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back stream: each instruction accepted on its first cycle
    for (int k = 0; k < 11; k++) begin
      send($sformatf("vec%0d", k), vi[k], 32'h100 + 32'(4 * k), ve[k], 1'b1, w);
      chk($sformatf("b2b_accept%0d", k), 64'(w), 64'd1);
    end

    // Load-use hazard: lw x2,0(x1) then add x3,x2,x1
    send("lw", 32'h0000A103, 32'h200, mk(32'h0000A103, 32'h200, 1,0,2, 0, 1,0,0,1, 1,0, 0, 0,1,0), 1'b1, w);
    in_valid = 1'b1;
    in_inst  = 32'h001101B3;
    in_pc    = 32'h204;
    @(negedge clk);
    chk("hazard_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_in_ready", 64'(in_ready), 64'd1);
    chk("bubble_perf", 64'(perf_bubbles), 64'd1);
    exp_q.push_back(mk(32'h001101B3, 32'h204, 2,1,3, 0, 0,0,0,0, 2,0, 0, 0,1,0));
    name_q.push_back("add_after_bubble");
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Hold with out_ready low, then flush with a concurrent input
    out_ready = 1'b0;
    send("held", 32'h00100413, 32'h300, ve[0], 1'b0, w);
    @(negedge clk);
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("hold_stable", 64'(out_inst), 64'h00100413);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h00200493;
    in_pc    = 32'h304;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_nop_inst", 64'(out_inst), 64'h13);
    chk("flush_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    chk("flush_dropped", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // M extension, div, and RV64-only ld on a 32-bit build
`ifdef RV_M_EXT_EN
    e_mul = mk(32'h022081B3, 32'h400, 1,2,3, 0, 0,0,0,0, 2,0, 2, 0,1,0);
`else
    e_mul = nop_exp(32'h022081B3, 32'h400);
`endif
    send("mul", 32'h022081B3, 32'h400, e_mul, 1'b1, w);
    send("div", 32'h0220C1B3, 32'h404, nop_exp(32'h0220C1B3, 32'h404), 1'b1, w);
    send("ld_rv32", 32'h0000B103, 32'h408, nop_exp(32'h0000B103, 32'h408), 1'b1, w);

    // RV64 instance: ld then lwu x2,-8(x1)
    in_valid64 = 1'b1;
    in_inst64  = 32'h0000B103;
    in_pc64    = 64'h1000;
    @(posedge clk);
    #1 in_inst64 = 32'hFF80E103;
    @(negedge clk);
    chk("ld64_valid", 64'(out_valid64), 64'd1);
    chk("ld64_size", 64'(out_inst_size64), 64'd3);
    chk("ld64_mem_read", 64'(out_mem_read64), 64'd1);
    chk("ld64_illegal", 64'(out_illegal64), 64'd0);
    @(posedge clk);
    #1 in_valid64 = 1'b0;
    @(negedge clk);
    chk("lwu64_imm", out_imm64, 64'hFFFFFFFFFFFFFFF8);
    chk("lwu64_signed", 64'(out_is_signed64), 64'd0);
    chk("lwu64_size", 64'(out_inst_size64), 64'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-stream, between clock edges
    send("sub_rst", 32'h402081B3, 32'h500, ve[1], 1'b0, w);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_reg_write", 64'(out_reg_write), 64'd1);
    chk("arst_alu_op", 64'(out_alu_op), 64'd0);
    chk("arst_perf", 64'(perf_bubbles), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_control_pipe.md
# id_control_pipe

Registered, parametrised instruction-decode stage. It replaces the purely combinational ID control decoder in the RV core pipeline.
- Accepts fetched instructions over a valid/ready handshake and decodes them into the existing control-signal set, plus register indices, sign-extended immediate and illegal-instruction flag.
- Presents the result one cycle later to EX.
- Detects load-use hazards against the instruction it currently holds and inserts exactly one bubble.
- Supports flush from branch resolution and RV64 loads/stores via `XLEN`.

## Interface
- `XLEN`, 32: datapath width, 32 or 64. Sizes `in_pc`, `out_pc`, `out_imm`. 64 enables `ld`/`sd`/`lwu` decode.
- `PERF_W`, 16: width of saturating bubble counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1 / `in_ready` out 1: fetch handshake.
- `in_inst` in 32, `in_pc` in XLEN: instruction and its PC.
- `flush` in 1: kill held and incoming instruction.
- `out_valid` out 1 / `out_ready` in 1: EX handshake.
- `out_inst` out 32, `out_pc` out XLEN.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each.
- `out_imm` out XLEN: sign-extended I/S/B/U/J immediate.
- `out_mem_read`, `out_mem_write`, `out_alu_src` out 1 each.
- `out_reg_write` out 1: active low.
- `out_mem_to_reg` out 2: 0 ALU-less/none, 1 memory, 2 ALU/link.
- `out_jump` out 2: 00 none, 01 branch, 10 jalr, 11 jal.
- `out_alu_op` out 4: ADD0 SUB1 MUL2 AND3 OR4 XOR5 SHL6 SHR7 SLT8 LUI9 BEQ10 BNE11 BGE12 BLT13.
- `out_inst_size` out 2: WORD 00, HALF 01, BYTE 10, DOUBLE 11.
- `out_is_signed` out 1.
- `out_illegal` out 1.
- `perf_bubbles` out PERF_W: count of inserted hazard bubbles, saturating.

## Operation
- **Transfer rules**
  - Input transfer when `in_valid && in_ready`. Output transfer when `out_valid && out_ready`.
  - `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- **Hazard**
  - Condition: `out_valid && out_mem_read && out_rd != 0 && in_valid`, and the incoming instruction reads that register.
  - rs1 is read by R, I, load, store, branch and jalr. rs2 is read by R, store and branch.
- **Bubble**: when hazard and `out_ready`, the register loads a bubble. `perf_bubbles` increments, saturating at all-ones.
- **NOP/bubble/illegal control values**
  - `mem_read=0`, `mem_write=0`, `reg_write=1`, `alu_src=0`, `mem_to_reg=0`, `jump=00`.
  - `alu_op=ADD`, `inst_size=WORD`, `is_signed=1`, `imm=0`.
  - `out_inst=0x00000013`, `out_pc=0`.
- **Unused fields** are driven 0, never X.
- **`out_valid` for bubbles and flushes**
  - A bubble loads with `out_valid=0`.
  - `flush` clears `out_valid` and loads NOP values next cycle, regardless of `out_ready`. A concurrent input is dropped.
  - `flush` overrides hazard; the bubble counter does not increment.
- **Illegal instructions**: unknown opcode or funct combination gives `out_valid=1`, `out_illegal=1`, NOP controls, and `out_pc`/`out_inst` preserved.
- **Decode table**
  - LUI: alu_src=1, mem_to_reg=2, alu_op=LUI.
  - AUIPC: ADD.
  - OP-IMM: alu_src=1, mem_to_reg=2.
  - LOAD: mem_read=1, alu_src=1, mem_to_reg=1.
  - STORE: mem_write=1, reg_write=1, alu_src=1.
  - R: mem_to_reg=2. SUB only for f7=0100000, f3=000.
  - BRANCH: jump=01, reg_write=1, BEQ/BNE/BLT/BGE.
  - JAL: jump=11, mem_to_reg=2, reg_write=0.
  - JALR: jump=10, alu_src=1, mem_to_reg=2, reg_write=0.
- **Signedness**: `is_signed=0` for lbu, lhu, lwu, sltu, sltiu, bltu, bgeu.
- **XLEN=32**: f3=011 loads/stores and lwu are illegal.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 per cycle with no hazard.
- Hazard costs exactly one bubble cycle.
- Output register holds stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_ready`, `flush` and the hazard compare.
- **Reset (asynchronous)**
  - `out_valid=0`, NOP values, `out_illegal=0`, `perf_bubbles=0`.
  - Effective immediately, including mid-transfer.
- **Simultaneous input transfer and output transfer**: new data replaces old in the same edge.

## Configuration
- `RV_M_EXT_EN` defined:
  - OP with f7=0000001 and f3=000–011 decodes to `alu_op=MUL`, reg_write=0, mem_to_reg=2.
  - f3=100–111 (div/rem) are illegal.
- Undefined: all f7=0000001 OP encodings are illegal.

## Structure
- Package `rv_ctrl_pkg`:
  - opcode localparams
  - ALU op codes
  - size codes
  - jump and mem_to_reg encodings
  - NOP instruction constant
- Sub-module `rv_decode_comb`:
  - purely combinational decode of `in_inst` to control, register indices, immediate, illegal and rs-use flags.
  - Parametrised by XLEN; instantiated once.
- Top: handshake, hazard compare, output register, perf counter.

## Test plan
- `reset` high mid-stream -> `out_valid=0`, `out_reg_write=1`, `out_alu_op=0`, `perf_bubbles=0` immediately.
- Back-to-back stream, `out_ready=1`:
  - `0x00500093` (addi x1,x0,5) -> next cycle `out_imm=5`, `out_alu_src=1`, `out_rd=1`, `out_mem_to_reg=2`.
  - Second instruction accepted same cycle.
- `0x0000A103` (lw x2,0(x1)) then `0x001101B3` (add x3,x2,x1):
  - `in_ready=0` one cycle.
  - One bubble with `out_valid=0`.
  - add appears next; `perf_bubbles=1`.
- `flush` while `out_valid=1` and `out_ready=0` -> next cycle `out_valid=0`; concurrent input dropped.
- `0x022081B3` (mul) -> `out_alu_op=2` with `RV_M_EXT_EN`, `out_illegal=1` without.
- XLEN=64: `0x0000B103` (ld) -> `out_inst_size=11`, `out_mem_read=1`. XLEN=32: same -> `out_illegal=1`.
